// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round count, key-schedule FSM states and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_WORD_W  = 32;
    localparam int unsigned AES_BYTE_W  = 8;
    localparam int unsigned NUM_ROUNDS  = 10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [AES_BYTE_W-1:0] xtime(input logic [AES_BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-schedule request/status and round-key read port, shared with the round datapath.
interface aes_key_expand_if;
    import aes_pkg::*;

    logic [AES_BLOCK_W-1:0] key_in;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   keys_valid;
    logic [3:0]             rk_idx;
    logic [AES_BLOCK_W-1:0] rk_out;

    modport master (
        output key_in, start, rk_idx,
        input  busy, done, keys_valid, rk_out
    );

    modport slave (
        input  key_in, start, rk_idx,
        output busy, done, keys_valid, rk_out
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per clock into an 11-entry register file, indexed read port.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter bit RK_READ_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    aes_key_expand_if.slave   bus
);

    ks_state_t              r_state;
    ks_state_t              w_state_nxt;
    logic [AES_BLOCK_W-1:0] r_cur;
    logic [3:0]             r_rnd;
    logic [AES_BYTE_W-1:0]  r_rcon;
    logic [AES_BLOCK_W-1:0] r_rk [0:NUM_ROUNDS];
    logic                   r_done;
    logic                   r_keys_valid;

    logic                   w_load;
    logic                   w_step;
    logic                   w_last;
    logic [AES_WORD_W-1:0]  w_rot;
    logic [AES_WORD_W-1:0]  w_sub;
    logic [AES_WORD_W-1:0]  w_temp;
    logic [AES_WORD_W-1:0]  w_n0, w_n1, w_n2, w_n3;
    logic [AES_BLOCK_W-1:0] w_next;
    logic [AES_BLOCK_W-1:0] w_rk_sel;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_step = 1'b1;
                if (r_rnd == 4'(NUM_ROUNDS)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // RotWord on w3, then SubWord through four shared S-box instances.
    assign w_rot = {r_cur[23:0], r_cur[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_temp = w_sub ^ {r_rcon, 24'h0};
    assign w_n0   = r_cur[127:96] ^ w_temp;
    assign w_n1   = r_cur[95:64]  ^ w_n0;
    assign w_n2   = r_cur[63:32]  ^ w_n1;
    assign w_n3   = r_cur[31:0]   ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur        <= '0;
            r_rnd        <= '0;
            r_rcon       <= '0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_rk[0]      <= bus.key_in;
                r_cur        <= bus.key_in;
                r_rnd        <= 4'd1;
                r_rcon       <= 8'h01;
                r_keys_valid <= 1'b0;
            end
            if (w_step) begin
                for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
                    if (r_rnd == 4'(i)) r_rk[i] <= w_next;
                end
                r_cur  <= w_next;
                r_rnd  <= r_rnd + 4'd1;
                r_rcon <= xtime(r_rcon);
            end
            if (w_last) r_keys_valid <= 1'b1;
        end
    end

    assign bus.busy       = (r_state == ST_EXPAND);
    assign bus.done       = r_done;
    assign bus.keys_valid = r_keys_valid;

    // Indices 11..15 match no entry and fall through to zero.
    always_comb begin
        w_rk_sel = '0;
        for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
            if (bus.rk_idx == 4'(i)) w_rk_sel = r_rk[i];
        end
    end

    if (RK_READ_REG) begin : g_rd_reg
        logic [AES_BLOCK_W-1:0] r_rk_out;
        always_ff @(posedge clk) begin
            if (reset) r_rk_out <= '0;
            else       r_rk_out <= w_rk_sel;
        end
        assign bus.rk_out = r_rk_out;
    end else begin : g_rd_comb
        assign bus.rk_out = w_rk_sel;
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and zero-key schedules, restart/abort cases, both read modes.
module tb_aes_key_expand;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0] fips_rk [11];
    logic [127:0] FIPS_KEY;
    logic [127:0] ZERO_KEY;

    aes_key_expand_if ka ();
    aes_key_expand_if kb ();

    aes_key_expand #(.RK_READ_REG(1'b0)) u_comb (
        .clk   (clk),
        .reset (reset),
        .bus   (ka)
    );

    aes_key_expand #(.RK_READ_REG(1'b1)) u_reg (
        .clk   (clk),
        .reset (reset),
        .bus   (kb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_start(input logic v);
        ka.start = v;
        kb.start = v;
    endtask

    // Pulse start for one edge; key_in is scrambled afterwards so late capture would show.
    task automatic start_key(input logic [127:0] key);
        ka.key_in = key;
        kb.key_in = key;
        set_start(1'b1);
        step();
        set_start(1'b0);
        ka.key_in = ~key;
        kb.key_in = ~key;
    endtask

    // Poll from the negedge after the start edge (cycle 0) through cycle last_c.
    task automatic wait_done(input string tag, input bit repulse, input int last_c);
        int dc  = -1;
        int cnt = 0;
        for (int c = 0; c <= last_c; c++) begin
            if (ka.done) begin
                cnt++;
                if (dc < 0) dc = c;
            end
            if (c == 0) chk({tag, "_busy0"}, 128'(ka.busy), 128'd1);
            if (c < last_c) begin
                if (repulse && (c == 3 || c == 7)) set_start(1'b1);
                step();
                set_start(1'b0);
            end
        end
        chk({tag, "_done_cycle"}, 128'(dc), 128'd10);
        chk({tag, "_done_count"}, 128'(cnt), 128'd1);
        chk({tag, "_keys_valid"}, 128'(ka.keys_valid), 128'd1);
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        ka.rk_idx = idx;
        #1;
        chk($sformatf("%s_rk%0d", tag, idx), ka.rk_out, exp);
    endtask

    task automatic check_fips_all(input string tag);
        for (int i = 0; i <= 10; i++) rd(tag, 4'(i), fips_rk[i]);
    endtask

    initial begin
        FIPS_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ZERO_KEY    = '0;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        ka.key_in = '0; ka.start = 1'b0; ka.rk_idx = '0;
        kb.key_in = '0; kb.start = 1'b0; kb.rk_idx = '0;

        // Reset state
        @(negedge clk);
        step();
        reset = 1'b0;
        chk("rst_busy",       128'(ka.busy),       128'd0);
        chk("rst_done",       128'(ka.done),       128'd0);
        chk("rst_keys_valid", 128'(ka.keys_valid), 128'd0);
        rd("rst", 4'd0, '0);
        chk("rst_reg_rk_out", kb.rk_out, '0);

        // Scenario 1: FIPS-197 key
        start_key(FIPS_KEY);
        wait_done("fips", 1'b0, 14);
        check_fips_all("fips");

        // Scenario 2: all-zero key
        start_key(ZERO_KEY);
        wait_done("zero", 1'b0, 14);
        rd("zero", 4'd0, '0);
        rd("zero", 4'd1, 128'h62636363626363636263636362636363);
        rd("zero", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Scenario 3: start re-pulsed mid-expansion is ignored
        start_key(FIPS_KEY);
        wait_done("repulse", 1'b1, 14);
        check_fips_all("repulse");

        // Scenario 4: reset during expansion
        start_key(ZERO_KEY);
        for (int c = 0; c < 4; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy",       128'(ka.busy),       128'd0);
        chk("abort_keys_valid", 128'(ka.keys_valid), 128'd0);
        rd("abort", 4'd0, '0);
        chk("abort_reg_rk_out", kb.rk_out, '0);
        start_key(FIPS_KEY);
        wait_done("after_abort", 1'b0, 14);
        rd("after_abort", 4'd1, fips_rk[1]);
        rd("after_abort", 4'd10, fips_rk[10]);

        // Scenario 6: out-of-range indices and registered read latency
        rd("oor", 4'd11, '0);
        rd("oor", 4'd15, '0);
        kb.rk_idx = 4'd0;
        step();
        chk("reg_rk0", kb.rk_out, fips_rk[0]);
        for (int i = 1; i <= 10; i++) begin
            kb.rk_idx = 4'(i);
            #1;
            chk($sformatf("reg_hold%0d", i), kb.rk_out, fips_rk[i-1]);
            step();
            chk($sformatf("reg_rk%0d", i), kb.rk_out, fips_rk[i]);
        end
        kb.rk_idx = 4'd11;
        step();
        chk("reg_oor11", kb.rk_out, '0);

        // Scenario 5: back-to-back keys, second start the cycle after done
        start_key(FIPS_KEY);
        wait_done("b2b_first", 1'b0, 10);
        start_key(ZERO_KEY);
        chk("b2b_keys_valid_drop", 128'(ka.keys_valid), 128'd0);
        wait_done("b2b_second", 1'b0, 14);
        rd("b2b", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
